// File: rtl/rmt_ctrl_pkg.sv
// rmt_ctrl_pkg
//   Shared definitions for the RMT control-path blocks (packet arbiter,
//   parser/stage control FSMs): arbiter state encoding, flush-beat constants
//   and the default control data/user widths.
//   No ports (package).
package rmt_ctrl_pkg;

  // Control-path default widths, shared with the parser/stage control FSMs.
  localparam int CTRL_DATA_WIDTH      = 256;
  localparam int CTRL_USER_WIDTH      = 128;
  localparam int CTRL_TIMEOUT_DEFAULT = 1024;
  localparam int CTRL_CNT_WIDTH       = 32;

  // Arbiter state encoding. The numeric values are relied upon by debug tooling.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_ABORT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } ctrl_arb_state_e;

  // Flush beat: a zero-content last beat. Downstream control FSMs treat any
  // tlast as end-of-packet and return to their first state.
  localparam logic FLUSH_TVALID = 1'b1;
  localparam logic FLUSH_TLAST  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant used by the control packet arbiter.
//   Ports:
//     req[1:0]    request per port (tvalid of each input stream)
//     last_grant  port that won the previous arbitration
//     grant       winning port (0 or 1); meaningful only when any_req = 1
//     any_req     at least one port is requesting
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_req
);

  // A tie goes to the port that lost last time; otherwise the sole requester wins.
  always_comb begin
    any_req = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
  end

endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// ctrl_pkt_arbiter
//   Packet-granular 2:1 round-robin arbiter for the control AXIS path that
//   programs the parser/stage action RAMs. Port 0 = host control stream,
//   port 1 = local reconfig engine. Packets are never interleaved, one idle
//   cycle follows every packet, and a packet that stalls for too long inside
//   its body is terminated with a zero-content flush beat.
//   Ports:
//     axis_clk, aresetn         clock, synchronous active-low reset
//     s0_axis_* / s1_axis_*     input streams (tdata, tuser, tkeep, tvalid, tlast, tready)
//     m_axis_*                  registered output stream, no backpressure
//     err_timeout               one-cycle pulse coincident with the flush beat
//   Optional feature macro CTRL_ARB_STATS_EN adds:
//     pkt_cnt0, pkt_cnt1        packets forwarded per port (wrapping)
//     abort_cnt                 timeouts taken (wrapping)
module ctrl_pkt_arbiter
  import rmt_ctrl_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = CTRL_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = CTRL_USER_WIDTH,
  parameter int C_TIMEOUT_CYCLES   = CTRL_TIMEOUT_DEFAULT,
  parameter int C_CNT_WIDTH        = CTRL_CNT_WIDTH
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,

  output logic                            err_timeout
`ifdef CTRL_ARB_STATS_EN
  ,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt1,
  output logic [C_CNT_WIDTH-1:0]          abort_cnt
`endif
);

  localparam int KW   = C_AXIS_DATA_WIDTH / 8;
  localparam int TO_W = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(C_TIMEOUT_CYCLES - 1);

  // A one-cycle timeout window would abort before any stall could be observed.
  if (C_TIMEOUT_CYCLES < 2 || C_CNT_WIDTH < 1) begin : g_bad_params
    $error("ctrl_pkt_arbiter: C_TIMEOUT_CYCLES must be >= 2 and C_CNT_WIDTH >= 1");
  end

  ctrl_arb_state_e         state;
  logic                    grant;
  logic                    last_grant;
  logic [TO_W-1:0]         to_cnt;

  logic                    arb_grant;
  logic                    any_req;
  logic                    port_open;

  logic                    g_valid;
  logic                    g_last;
  logic [C_AXIS_DATA_WIDTH-1:0]  g_data;
  logic [C_AXIS_TUSER_WIDTH-1:0] g_user;
  logic [KW-1:0]           g_keep;

  rr_arb2 u_rr_arb2 (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  // tready depends only on registered state so it never loops back through tvalid.
  assign port_open      = (state == ST_FWD) || (state == ST_DRAIN);
  assign s0_axis_tready = port_open && !grant;
  assign s1_axis_tready = port_open &&  grant;

  // View of the currently granted input stream.
  always_comb begin
    if (grant) begin
      g_valid = s1_axis_tvalid;
      g_last  = s1_axis_tlast;
      g_data  = s1_axis_tdata;
      g_user  = s1_axis_tuser;
      g_keep  = s1_axis_tkeep;
    end else begin
      g_valid = s0_axis_tvalid;
      g_last  = s0_axis_tlast;
      g_data  = s0_axis_tdata;
      g_user  = s0_axis_tuser;
      g_keep  = s0_axis_tkeep;
    end
  end

  // Arbiter FSM with the stall timer and the registered output beat.
  // tvalid and err_timeout default low so each is a single-cycle pulse;
  // payload registers simply hold while tvalid is low.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      to_cnt        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      err_timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (any_req) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
            state      <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (g_valid) begin
            m_axis_tdata  <= g_data;
            m_axis_tuser  <= g_user;
            m_axis_tkeep  <= g_keep;
            m_axis_tlast  <= g_last;
            m_axis_tvalid <= 1'b1;
            to_cnt        <= '0;
            if (g_last) state <= ST_GAP;
          end else if (to_cnt == TO_LAST) begin
            state <= ST_ABORT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_ABORT: begin
          m_axis_tdata  <= '0;
          m_axis_tuser  <= '0;
          m_axis_tkeep  <= '0;
          m_axis_tlast  <= FLUSH_TLAST;
          m_axis_tvalid <= FLUSH_TVALID;
          err_timeout   <= 1'b1;
          to_cnt        <= '0;
          state         <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Remainder of the aborted packet is swallowed; no timer here.
          if (g_valid && g_last) state <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_ARB_STATS_EN
  // Statistics: only packets completed through FWD count as forwarded;
  // a packet cut short by a timeout is counted once in abort_cnt instead.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      abort_cnt <= '0;
    end else begin
      if (state == ST_FWD && g_valid && g_last) begin
        if (grant) pkt_cnt1 <= pkt_cnt1 + C_CNT_WIDTH'(1);
        else       pkt_cnt0 <= pkt_cnt0 + C_CNT_WIDTH'(1);
      end
      if (state == ST_ABORT) abort_cnt <= abort_cnt + C_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// tb_ctrl_pkt_arbiter
//   Self-checking bench for ctrl_pkt_arbiter. Each scenario is a per-port list
//   of packets (length, pre-packet gap, per-beat stalls, payload). A packet-level
//   timeline model derives, for every cycle, the expected output beat,
//   err_timeout and tready of each port; a monitor compares at the negative edge.
//   Define CTRL_ARB_STATS_EN to also check the statistics counters.
module tb_ctrl_pkt_arbiter;

  localparam int DW   = 256;
  localparam int UW   = 128;
  localparam int KW   = DW / 8;
  localparam int TO   = 8;
  localparam int CW   = 8;
  localparam int MAXP = 160;
  localparam int MAXB = 6;
  localparam int HOR  = 4096;
  localparam int WAIT_LIMIT = 400;

  logic axis_clk = 1'b0;
  logic aresetn  = 1'b0;
  always #5 axis_clk = ~axis_clk;

  logic [DW-1:0] in_data  [2];
  logic [UW-1:0] in_user  [2];
  logic [KW-1:0] in_keep  [2];
  logic          in_valid [2];
  logic          in_last  [2];

  logic          s0_axis_tready, s1_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, err_timeout;
`ifdef CTRL_ARB_STATS_EN
  logic [CW-1:0] pkt_cnt0, pkt_cnt1, abort_cnt;
`endif

  ctrl_pkt_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .C_TIMEOUT_CYCLES   (TO),
    .C_CNT_WIDTH        (CW)
  ) dut (
    .axis_clk       (axis_clk),
    .aresetn        (aresetn),
    .s0_axis_tdata  (in_data[0]),
    .s0_axis_tuser  (in_user[0]),
    .s0_axis_tkeep  (in_keep[0]),
    .s0_axis_tvalid (in_valid[0]),
    .s0_axis_tlast  (in_last[0]),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (in_data[1]),
    .s1_axis_tuser  (in_user[1]),
    .s1_axis_tkeep  (in_keep[1]),
    .s1_axis_tvalid (in_valid[1]),
    .s1_axis_tlast  (in_last[1]),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .err_timeout    (err_timeout)
`ifdef CTRL_ARB_STATS_EN
    ,
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .abort_cnt      (abort_cnt)
`endif
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit running     = 1'b0;

  // Stimulus plan
  int            npkt   [2];
  int            plen   [2][MAXP];
  int            pgap   [2][MAXP];
  int            bstall [2][MAXP][MAXB];
  logic [DW-1:0] bdata  [2][MAXP][MAXB];
  logic [UW-1:0] buser  [2][MAXP][MAXB];
  logic [KW-1:0] bkeep  [2][MAXP][MAXB];

  // Expected per-cycle behaviour
  bit            ev    [HOR];
  bit            elast [HOR];
  bit            eerr  [HOR];
  bit            erdy  [2][HOR];
  logic [DW-1:0] edata [HOR];
  logic [UW-1:0] euser [HOR];
  logic [KW-1:0] ekeep [HOR];
  int            endCyc;
  int            expPkt [2];
  int            expAbort;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  // Monitor: compare every cycle of a scenario against the model.
  always @(negedge axis_clk) begin
    if (!running) begin
      cyc = 0;
    end else begin
      if (cyc < HOR) begin
        checkOutput("m_tvalid", DW'(m_axis_tvalid), DW'(ev[cyc]));
        if (ev[cyc]) begin
          checkOutput("m_tlast", DW'(m_axis_tlast), DW'(elast[cyc]));
          checkOutput("m_tdata", m_axis_tdata, edata[cyc]);
          checkOutput("m_tuser", DW'(m_axis_tuser), DW'(euser[cyc]));
          checkOutput("m_tkeep", DW'(m_axis_tkeep), DW'(ekeep[cyc]));
        end
        checkOutput("err_timeout", DW'(err_timeout), DW'(eerr[cyc]));
        checkOutput("s0_tready", DW'(s0_axis_tready), DW'(erdy[0][cyc]));
        checkOutput("s1_tready", DW'(s1_axis_tready), DW'(erdy[1][cyc]));
      end
      cyc = cyc + 1;
    end
  end

  task automatic clearStim();
    npkt[0] = 0;
    npkt[1] = 0;
  endtask

  task automatic addPkt(input int p, input int len, input int gap);
    int k;
    k = npkt[p];
    plen[p][k] = len;
    pgap[p][k] = gap;
    for (int j = 0; j < MAXB; j++) begin
      bstall[p][k][j] = 0;
      for (int w = 0; w < DW / 32; w++) bdata[p][k][j][w*32 +: 32] = $urandom();
      for (int w = 0; w < UW / 32; w++) buser[p][k][j][w*32 +: 32] = $urandom();
      bkeep[p][k][j] = $urandom();
    end
    npkt[p] = k + 1;
  endtask

  task automatic markRdy(input int p, input int first, input int last);
    for (int c = first; c <= last; c++) if (c < HOR) erdy[p][c] = 1'b1;
  endtask

  task automatic emitBeat(input int c, input int p, input int k, input int j);
    if (c < HOR) begin
      ev[c]    = 1'b1;
      elast[c] = (j == plen[p][k] - 1);
      edata[c] = bdata[p][k][j];
      euser[c] = buser[p][k][j];
      ekeep[c] = bkeep[p][k][j];
    end
  endtask

  // Packet-level timeline. Cycle 0 is the first cycle after reset release.
  // A grant decided in IDLE cycle t opens the port at t+1; beat acceptance at
  // cycle a shows on m_axis at a+1; a packet ending at e leaves GAP at e+1
  // and the arbiter idle again at e+2. A stall of TO or more cycles aborts:
  // port closed in cycle a+TO+1, flush beat at a+TO+2, then the rest drains.
  task automatic computeModel();
    int  t, g, lastG, acc, s, ds, kk, len;
    int  k  [2];
    int  rt [2];
    bit  r0, r1, aborted;
    for (int c = 0; c < HOR; c++) begin
      ev[c] = 0; elast[c] = 0; eerr[c] = 0; erdy[0][c] = 0; erdy[1][c] = 0;
      edata[c] = '0; euser[c] = '0; ekeep[c] = '0;
    end
    expPkt[0] = 0; expPkt[1] = 0; expAbort = 0;
    t = 0; lastG = 1; k[0] = 0; k[1] = 0;
    for (int p = 0; p < 2; p++) rt[p] = (npkt[p] > 0) ? pgap[p][0] : 0;
    while (k[0] < npkt[0] || k[1] < npkt[1]) begin
      r0 = (k[0] < npkt[0]) && (rt[0] <= t);
      r1 = (k[1] < npkt[1]) && (rt[1] <= t);
      if (!r0 && !r1) begin
        t = 1 << 30;
        if (k[0] < npkt[0] && rt[0] < t) t = rt[0];
        if (k[1] < npkt[1] && rt[1] < t) t = rt[1];
        continue;
      end
      g = (r0 && r1) ? 1 - lastG : (r1 ? 1 : 0);
      lastG = g;
      kk  = k[g];
      len = plen[g][kk];
      acc = t + 1;
      markRdy(g, acc, acc);
      emitBeat(acc + 1, g, kk, 0);
      aborted = 1'b0;
      for (int j = 1; j < len; j++) begin
        s = bstall[g][kk][j];
        if (!aborted && s >= TO) begin
          markRdy(g, acc + 1, acc + TO);
          ds = acc + TO + 2;
          if (ds < HOR) begin
            ev[ds] = 1'b1; elast[ds] = 1'b1; eerr[ds] = 1'b1;
          end
          acc = (acc + 1 + s > ds) ? acc + 1 + s : ds;
          markRdy(g, ds, acc);
          aborted = 1'b1;
          expAbort++;
        end else begin
          markRdy(g, acc + 1, acc + 1 + s);
          acc = acc + 1 + s;
          if (!aborted) emitBeat(acc + 1, g, kk, j);
        end
      end
      if (!aborted) expPkt[g]++;
      t = acc + 2;
      rt[g] = acc + 1 + ((kk + 1 < npkt[g]) ? pgap[g][kk + 1] : 0);
      k[g]++;
    end
    endCyc = t;
  endtask

  // Well-behaved AXIS source: holds each beat until it sees tready.
  task automatic applyStimulus(input int p);
    bit rdy;
    int waitCnt;
    for (int k = 0; k < npkt[p]; k++) begin
      in_valid[p] = 1'b0;
      repeat (pgap[p][k]) begin @(posedge axis_clk); #1; end
      for (int j = 0; j < plen[p][k]; j++) begin
        if (j > 0) begin
          repeat (bstall[p][k][j]) begin
            in_valid[p] = 1'b0;
            @(posedge axis_clk); #1;
          end
        end
        in_valid[p] = 1'b1;
        in_data[p]  = bdata[p][k][j];
        in_user[p]  = buser[p][k][j];
        in_keep[p]  = bkeep[p][k][j];
        in_last[p]  = (j == plen[p][k] - 1);
        waitCnt = 0;
        do begin
          rdy = (p == 0) ? s0_axis_tready : s1_axis_tready;
          @(posedge axis_clk); #1;
          waitCnt++;
        end while (!rdy && waitCnt < WAIT_LIMIT);
        if (!rdy) begin
          checkOutput("beat_accept_timeout", DW'(0), DW'(1));
          in_valid[p] = 1'b0;
          return;
        end
      end
    end
    in_valid[p] = 1'b0;
    in_last[p]  = 1'b0;
  endtask

  task automatic applyReset();
    aresetn = 1'b0;
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0; in_last[p] = 1'b0;
      in_data[p] = '0; in_user[p] = '0; in_keep[p] = '0;
    end
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    checkOutput("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("rst_m_tdata", m_axis_tdata, DW'(0));
    checkOutput("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
    checkOutput("rst_err", DW'(err_timeout), DW'(0));
    checkOutput("rst_tready", DW'({s1_axis_tready, s0_axis_tready}), DW'(0));
    @(posedge axis_clk); #1;
    aresetn = 1'b1;
  endtask

  task automatic runScenario(input string name);
    computeModel();
    $display("[TB] scenario %s: %0d+%0d packets, model end cycle %0d",
             name, npkt[0], npkt[1], endCyc);
    applyReset();
    running = 1'b1;
    fork
      applyStimulus(0);
      applyStimulus(1);
    join
    while (cyc <= endCyc + 3) @(negedge axis_clk);
    running = 1'b0;
`ifdef CTRL_ARB_STATS_EN
    checkOutput("pkt_cnt0", DW'(pkt_cnt0), DW'(expPkt[0] % (1 << CW)));
    checkOutput("pkt_cnt1", DW'(pkt_cnt1), DW'(expPkt[1] % (1 << CW)));
    checkOutput("abort_cnt", DW'(abort_cnt), DW'(expAbort % (1 << CW)));
`endif
  endtask

  // Reset pulse in the middle of a port-1 packet, then a tie from reset.
  task automatic resetMidPacket();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    applyReset();
    in_valid[1] = 1'b1; in_data[1] = d; in_last[1] = 1'b0; in_keep[1] = '1;
    repeat (3) begin @(posedge axis_clk); #1; end
    @(negedge axis_clk);
    checkOutput("mid_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    checkOutput("mid_m_tdata", m_axis_tdata, d);
    aresetn = 1'b0;
    @(posedge axis_clk); #1;
    aresetn = 1'b1;
    in_valid[1] = 1'b0;
    @(negedge axis_clk);
    checkOutput("mrst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("mrst_m_tdata", m_axis_tdata, DW'(0));
    checkOutput("mrst_m_tkeep", DW'(m_axis_tkeep), DW'(0));
    checkOutput("mrst_tready", DW'({s1_axis_tready, s0_axis_tready}), DW'(0));
`ifdef CTRL_ARB_STATS_EN
    checkOutput("mrst_pkt_cnt1", DW'(pkt_cnt1), DW'(0));
`endif
    in_valid[0] = 1'b1; in_last[0] = 1'b1;
    in_valid[1] = 1'b1; in_last[1] = 1'b1;
    @(posedge axis_clk);
    @(negedge axis_clk);
    checkOutput("mrst_tie_grant", DW'({s1_axis_tready, s0_axis_tready}), DW'(2'b01));
    @(posedge axis_clk); #1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0; in_last[p] = 1'b0;
      in_data[p] = '0; in_user[p] = '0; in_keep[p] = '0;
    end

    clearStim();
    addPkt(0, 4, 0);
    runScenario("single_4beat_s0");

    clearStim();
    addPkt(0, 2, 0); addPkt(0, 2, 0);
    addPkt(1, 2, 0); addPkt(1, 2, 0);
    runScenario("tie_alternation");

    clearStim();
    addPkt(1, 1, 2);
    runScenario("single_beat_s1");

    clearStim();
    addPkt(0, 4, 1);
    bstall[0][0][2] = 20;
    runScenario("stall_timeout");

    resetMidPacket();

    clearStim();
    for (int i = 0; i < 150; i++) begin
      addPkt(0, 1, 0);
      addPkt(1, 1, 0);
    end
    runScenario("back_to_back_300");

    for (int r = 0; r < 8; r++) begin
      clearStim();
      for (int p = 0; p < 2; p++) begin
        int n;
        n = $urandom_range(6, 1);
        for (int k = 0; k < n; k++) begin
          addPkt(p, $urandom_range(5, 1), $urandom_range(4, 0));
          for (int j = 1; j < MAXB; j++)
            bstall[p][k][j] = ($urandom_range(7, 0) == 0) ? $urandom_range(12, TO - 1)
                                                          : $urandom_range(3, 0);
        end
      end
      runScenario($sformatf("random_%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
